// File: rtl/calc_pkg.sv
// calc_pkg: state, key-code and status encodings shared by the keypad calculator
package calc_pkg;
  typedef enum logic [2:0] {WAIT_A, WAIT_B, CALC, PRINT, ERROR} state_t;
  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13, K_EQ = 4'd14, K_BS = 4'd15;
  localparam logic [1:0] S_ERROR = 2'b00, S_BUSY = 2'b01, S_READY = 2'b10, S_PRINT = 2'b11;
endpackage

// File: rtl/calc_param_if.sv
// calc_param_if: key handshake and serial display bus of the calculator
interface calc_param_if #(parameter int NDIGITS = 8);
  localparam int PW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  logic [3:0] cmd;
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] status;
  logic [3:0] data;
  logic [PW-1:0] pos;
  logic data_valid;
  logic neg;
  logic [2:0] state;
  modport slave (input cmd, cmd_valid, output cmd_ready, status, data, pos, data_valid, neg, state);
  modport master (output cmd, cmd_valid, input cmd_ready, status, data, pos, data_valid, neg, state);
endinterface

// File: rtl/calc_digit_printer.sv
// calc_digit_printer: serialises a loaded value LSD-first as NDIGITS BCD digits
module calc_digit_printer #(
  parameter int NDIGITS = 8,
  parameter int WIDTH = 27,
  localparam int PW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic [WIDTH-1:0] value,
  output logic [3:0] data,
  output logic [PW-1:0] pos,
  output logic data_valid,
  output logic done
);
  logic [WIDTH-1:0] val_q, val_d;
  logic [PW-1:0] pos_q, pos_d;
  logic act_q, act_d;
  assign done = act_q && pos_q == PW'(NDIGITS - 1);
  assign data = act_q ? 4'(val_q % WIDTH'(10)) : 4'd0;
  assign pos = pos_q;
  assign data_valid = act_q;
  always_comb begin
    val_d = load ? value : val_q / WIDTH'(10);
    pos_d = (load || done) ? '0 : act_q ? pos_q + 1'b1 : pos_q;
    act_d = load || (act_q && !done);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      val_q <= '0;
      pos_q <= '0;
      act_q <= 1'b0;
    end else begin
      val_q <= val_d;
      pos_q <= pos_d;
      act_q <= act_d;
    end
  end
endmodule

// File: rtl/calc_param.sv
// calc_param: NDIGITS-digit decimal keypad calculator with add/sub/multiply and serial display
module calc_param import calc_pkg::*; #(
  parameter int NDIGITS = 8,
  parameter int WIDTH = 27
) (
  input logic clock,
  input logic reset,
  calc_param_if.slave bus
);
  localparam int CW = $clog2(NDIGITS + 1);
  localparam int MW = $clog2(WIDTH);
  localparam logic [63:0] MAXVAL64 = 64'(10) ** NDIGITS - 64'd1;
  localparam logic [WIDTH-1:0] MAXVAL = WIDTH'(MAXVAL64);
  if ((64'd1 << WIDTH) <= MAXVAL64) begin : g_width_chk
    $error("calc_param: WIDTH cannot hold 10**NDIGITS-1");
  end
  state_t state_q, state_d, ret_q, ret_d;
  logic [WIDTH-1:0] acc_q, acc_d, rega_q, rega_d, b, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [3:0] op_q, op_d;
  logic neg_q, neg_d, res_q, res_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_n;
  logic [WIDTH:0] sum, msum;
  logic take, is_digit, is_op, is_sub, is_mul, sub_neg, ovf, calc_done, pr_load, pr_done;
  assign take = bus.cmd_valid && bus.cmd_ready;
  assign is_digit = bus.cmd <= 4'd9;
  assign is_op = bus.cmd inside {K_ADD, K_SUB, K_MUL};
  assign is_sub = op_q == K_SUB;
  assign is_mul = op_q == K_MUL;
  // low half of prod_q holds regB until the shift-add multiplier consumes it
  assign b = prod_q[WIDTH-1:0];
  assign sum = {1'b0, rega_q} + {1'b0, b};
  assign msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, rega_q} : '0);
  assign prod_n = {msum, prod_q[WIDTH-1:1]};
  assign sub_neg = rega_q < b;
  assign res = is_mul ? prod_n[WIDTH-1:0] : is_sub ? (sub_neg ? b - rega_q : rega_q - b) : sum[WIDTH-1:0];
  assign ovf = is_mul ? prod_n > {{WIDTH{1'b0}}, MAXVAL} : !is_sub && sum > {1'b0, MAXVAL};
  assign calc_done = !is_mul || mcnt_q == MW'(WIDTH - 1);
  assign pr_load = state_d == PRINT && state_q != PRINT;
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    res_d = res_q;
    rega_d = rega_q;
    prod_d = prod_q;
    op_d = op_q;
    mcnt_d = mcnt_q;
    case (state_q)
      WAIT_A, WAIT_B: if (take) begin
        if (is_digit) begin
          if (res_q || cnt_q < CW'(NDIGITS)) begin
            acc_d = (res_q ? '0 : acc_q) * WIDTH'(10) + WIDTH'(bus.cmd);
            cnt_d = (res_q ? '0 : cnt_q) + 1'b1;
            neg_d = res_q ? 1'b0 : neg_q;
            res_d = 1'b0;
            state_d = PRINT;
            ret_d = state_q;
          end
        end else if (bus.cmd == K_BS) begin
          acc_d = acc_q / WIDTH'(10);
          cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
          state_d = PRINT;
          ret_d = state_q;
        end else if (bus.cmd == K_CLR) begin
          acc_d = '0;
          cnt_d = '0;
          neg_d = 1'b0;
          state_d = PRINT;
          ret_d = state_q;
        end else if (is_op && state_q == WAIT_A) begin
          rega_d = acc_q;
          op_d = bus.cmd;
          acc_d = '0;
          cnt_d = '0;
          res_d = 1'b0;
          neg_d = 1'b0;
          state_d = WAIT_B;
        end else if (is_op && cnt_q == '0) begin
          op_d = bus.cmd;
        end else if (bus.cmd == K_EQ && state_q == WAIT_B) begin
          prod_d = {{WIDTH{1'b0}}, acc_q};
          mcnt_d = '0;
          state_d = CALC;
        end
      end
      CALC: if (!calc_done) begin
        prod_d = prod_n;
        mcnt_d = mcnt_q + 1'b1;
      end else if (ovf) begin
        state_d = ERROR;
      end else begin
        acc_d = res;
        cnt_d = CW'(NDIGITS);
        res_d = 1'b1;
        neg_d = is_sub && sub_neg;
        state_d = PRINT;
        ret_d = WAIT_A;
      end
      PRINT: state_d = pr_done ? ret_q : PRINT;
      ERROR: if (take && bus.cmd == K_CLR) begin
        acc_d = '0;
        cnt_d = '0;
        neg_d = 1'b0;
        res_d = 1'b0;
        rega_d = '0;
        prod_d = '0;
        op_d = '0;
        mcnt_d = '0;
        ret_d = WAIT_A;
        state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end
  always_comb begin
    bus.status = state_q == ERROR ? S_ERROR : state_q == CALC ? S_BUSY : state_q == PRINT ? S_PRINT : S_READY;
    bus.cmd_ready = state_q inside {WAIT_A, WAIT_B, ERROR};
    bus.neg = neg_q;
    bus.state = state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_A;
      ret_q <= WAIT_A;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      res_q <= 1'b0;
      rega_q <= '0;
      prod_q <= '0;
      op_q <= '0;
      mcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      res_q <= res_d;
      rega_q <= rega_d;
      prod_q <= prod_d;
      op_q <= op_d;
      mcnt_q <= mcnt_d;
    end
  end
  calc_digit_printer #(.NDIGITS(NDIGITS), .WIDTH(WIDTH)) u_printer (
    .clock(clock),
    .reset(reset),
    .load(pr_load),
    .value(acc_d),
    .data(bus.data),
    .pos(bus.pos),
    .data_valid(bus.data_valid),
    .done(pr_done)
  );
endmodule

// File: tb/tb_calc_param.sv
// tb_calc_param: randomized scoreboard bench for calc_param against a decimal reference model
module tb_calc_param;
  import calc_pkg::*;
  localparam longint MAXV = 99999999;
  typedef struct {logic [3:0] d; int p; bit n;} dig_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  calc_param_if #(.NDIGITS(8)) bus();
  calc_param #(.NDIGITS(8), .WIDTH(27)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  int total = 0, fails = 0, busy = 0;
  dig_t exp_q[$];
  dig_t e;
  longint shown = 0, scale = 1, last_shown = -1;
  bit last_neg;
  longint m_acc, m_a;
  int m_cnt, m_op, m_mode;
  bit m_neg, m_res;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  function automatic void model_reset();
    m_acc = 0; m_a = 0; m_cnt = 0; m_op = 0; m_mode = 0; m_neg = 0; m_res = 0;
  endfunction
  function automatic void push_val(longint v, bit n);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{d: 4'(v % 10), p: i, n: n});
      v = v / 10;
    end
  endfunction
  // decimal calculator rules: mode 0 entering A, 1 entering B, 2 error
  function automatic void model_key(int k);
    longint r;
    if (m_mode == 2) begin
      if (k == 13) model_reset();
      return;
    end
    if (k <= 9) begin
      if (m_res) begin m_acc = 0; m_cnt = 0; m_neg = 0; m_res = 0; end
      if (m_cnt < 8) begin
        m_acc = m_acc * 10 + k;
        m_cnt++;
        push_val(m_acc, m_neg);
      end
    end else if (k == 15) begin
      m_acc = m_acc / 10;
      if (m_cnt > 0) m_cnt--;
      push_val(m_acc, m_neg);
    end else if (k == 13) begin
      m_acc = 0; m_cnt = 0; m_neg = 0;
      push_val(0, 0);
    end else if (k <= 12) begin
      if (m_mode == 0) begin
        m_a = m_acc; m_op = k; m_acc = 0; m_cnt = 0; m_res = 0; m_neg = 0; m_mode = 1;
      end else if (m_cnt == 0) m_op = k;
    end else if (m_mode == 1) begin
      r = m_op == 10 ? m_a + m_acc : m_op == 11 ? (m_a >= m_acc ? m_a - m_acc : m_acc - m_a) : m_a * m_acc;
      if (r > MAXV) m_mode = 2;
      else begin
        m_neg = m_op == 11 && m_a < m_acc;
        m_acc = r; m_cnt = 8; m_res = 1; m_mode = 0;
        push_val(r, m_neg);
      end
    end
  endfunction
  function automatic longint exp_state();
    return m_mode == 0 ? longint'(WAIT_A) : m_mode == 1 ? longint'(WAIT_B) : longint'(ERROR);
  endfunction
  always @(negedge clock) if (bus.data_valid) begin
    if (exp_q.size() == 0) begin
      total++;
      fails++;
      $display("FAIL unexpected_digit: got digit %0d at pos %0d, required no output", bus.data, bus.pos);
    end else begin
      e = exp_q.pop_front();
      chk("digit", bus.data, e.d);
      chk("pos", bus.pos, e.p);
      chk("neg", bus.neg, e.n);
    end
    chk("print_status", bus.status, 3);
    if (bus.pos == 0) begin shown = 0; scale = 1; end
    shown += bus.data * scale;
    scale *= 10;
    if (bus.pos == 7) begin last_shown = shown; last_neg = bus.neg; end
  end
  // waits out CALC/PRINT while pulsing random keys that must be ignored
  task automatic wait_idle();
    int n = 0;
    busy = 0;
    @(negedge clock);
    while ((bus.status == 2'b01 || bus.status == 2'b11) && n < 400) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd = 4'($urandom);
      if (bus.status == 2'b01) busy++;
      n++;
      @(negedge clock);
    end
    bus.cmd_valid = 1'b0;
    chk("idle_timeout", longint'(n < 400), 1);
  endtask
  task automatic key(input int k);
    bit took;
    @(negedge clock);
    bus.cmd = 4'(k);
    bus.cmd_valid = 1'b1;
    took = bus.cmd_ready;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    if (took) model_key(k);
    wait_idle();
    chk("state", bus.state, exp_state());
    chk("status", bus.status, m_mode == 2 ? 0 : 2);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic run(input int s[$]);
    foreach (s[i]) key(s[i]);
  endtask
  initial begin
    int s[$];
    int r;
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_status", bus.status, 2);
    chk("rst_state", bus.state, WAIT_A);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_neg", bus.neg, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_pos", bus.pos, 0);
    chk("rst_data", bus.data, 0);
    @(negedge clock) reset = 1'b0;
    s = '{1, 2, 3}; run(s);
    chk("t2_value", last_shown, 123);
    s = '{13, 1, 2, 3, 10, 4, 5, 14}; run(s);
    chk("t3_sum", last_shown, 168);
    chk("t3_neg", last_neg, 0);
    s = '{12, 2, 14}; run(s);
    chk("t3_chain", last_shown, 336);
    s = '{5, 11, 9, 14}; run(s);
    chk("t4_diff", last_shown, 4);
    chk("t4_neg", last_neg, 1);
    s = '{1, 2, 3, 4, 12, 5, 6, 7, 8, 14}; run(s);
    chk("t5_busy_long", longint'(busy >= 27), 1);
    chk("t5_product", last_shown, 7006652);
    s = '{9, 9, 9, 9, 9, 9, 9, 9, 10, 1, 14}; run(s);
    chk("t6_err_status", bus.status, 0);
    s = '{3, 15, 14}; run(s);
    chk("t6_err_hold", bus.state, ERROR);
    s = '{13}; run(s);
    chk("t6_clr_status", bus.status, 2);
    chk("t6_clr_state", bus.state, WAIT_A);
    s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 15, 15}; run(s);
    chk("t7_backspace", last_shown, 123456);
    @(negedge clock);
    bus.cmd = 4'd13;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    model_key(13);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t1_status", bus.status, 2);
    chk("t1_state", bus.state, WAIT_A);
    chk("t1_data_valid", bus.data_valid, 0);
    chk("t1_ready", bus.cmd_ready, 1);
    exp_q.delete();
    model_reset();
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      key(r < 12 ? $urandom_range(0, 9) : r < 15 ? r - 2 : r < 17 ? 14 : r == 18 ? 15 : 13);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
